// File: rtl/adder_pkg.sv
// adder_pkg: shared types and helpers for the pipelined carry-lookahead adder
package adder_pkg;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;
    typedef struct packed {
        logic cout;
        logic c_msb_in;
    } lane_res_t;
    function automatic int lanes(int width, int lane_w);
        return width / lane_w;
    endfunction
endpackage

// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand/result handshake bundle for the pipelined adder
interface pipelined_cla_adder_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, cin, sub;
    logic out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_lane.sv
// cla_lane: combinational lane adder built from 4-bit lookahead groups rippled group to group
module cla_lane
    import adder_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    output logic [LANE_W-1:0] sum,
    output lane_res_t         res
);
    localparam int GROUPS = LANE_W / 4;
    for (genvar n = 0; n < GROUPS; n++) begin : g_grp
        logic [3:0] gg, pp;
        logic [4:1] cc;
        logic ci;
        if (n == 0) begin : g_c
            assign ci = cin;
        end else begin : g_c
            assign ci = g_grp[n-1].cc[4];
        end
        assign gg = a[4*n +: 4] & b[4*n +: 4];
        assign pp = a[4*n +: 4] ^ b[4*n +: 4];
        assign cc[1] = gg[0] | (pp[0] & ci);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & ci);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & ci);
        assign cc[4] = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]) | (&pp & ci);
        assign sum[4*n +: 4] = pp ^ {cc[3:1], ci};
    end
    assign res.cout = g_grp[GROUPS-1].cc[4];
    assign res.c_msb_in = g_grp[GROUPS-1].cc[3];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: one carry-lookahead lane per stage, carry registered between stages,
// upper operand lanes skewed forward and finished result lanes de-skewed alongside
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8
) (
    input logic clk,
    input logic rst,
    pipelined_cla_adder_if.slave io
);
    localparam int STAGES = lanes(WIDTH, LANE_W);
    if (WIDTH <= 0 || LANE_W <= 0 || WIDTH % LANE_W != 0 || LANE_W % 4 != 0) begin : g_chk
        $fatal(1, "pipelined_cla_adder: WIDTH must be a positive multiple of LANE_W, LANE_W a multiple of 4");
    end
    logic adv;
    add_op_e op;
    logic [WIDTH-1:0] bx;
    logic [LANE_W-1:0] ls [STAGES];
    lane_res_t fl [STAGES];
    assign op = add_op_e'(io.sub);
    assign bx = op == OP_SUB ? ~io.b : io.b;
    assign adv = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = (k + 1) * LANE_W;
        localparam int IW = WIDTH - k * LANE_W;
        logic v, c, vi, ci;
        logic [IW-1:0] sa, sb;
        logic [RW-1:0] r, rn;
        if (k == 0) begin : g_src
            assign sa = io.a;
            assign sb = bx;
            assign vi = io.in_valid;
            assign ci = op == OP_SUB || io.cin;
            assign rn = ls[0];
        end else begin : g_src
            assign sa = g_st[k-1].g_sk.ua;
            assign sb = g_st[k-1].g_sk.ub;
            assign vi = g_st[k-1].v;
            assign ci = g_st[k-1].c;
            assign rn = {ls[k], g_st[k-1].r};
        end
        cla_lane #(.LANE_W(LANE_W)) u_lane (
            .a  (sa[LANE_W-1:0]),
            .b  (sb[LANE_W-1:0]),
            .cin(ci),
            .sum(ls[k]),
            .res(fl[k])
        );
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                c <= 1'b0;
                r <= '0;
            end else if (adv) begin
                v <= vi;
                c <= fl[k].cout;
                r <= rn;
            end
        end
        // Lanes not yet added travel forward unchanged until their stage
        if (k < STAGES - 1) begin : g_sk
            logic [IW-LANE_W-1:0] ua, ub;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ua <= '0;
                    ub <= '0;
                end else if (adv) begin
                    ua <= sa[IW-1:LANE_W];
                    ub <= sb[IW-1:LANE_W];
                end
            end
        end else begin : g_ov
            logic o;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) o <= 1'b0;
                else if (adv) o <= fl[k].c_msb_in ^ fl[k].cout;
            end
        end
    end
    assign io.out_valid = g_st[STAGES-1].v;
    assign io.sum = g_st[STAGES-1].r;
    assign io.cout = g_st[STAGES-1].c;
    assign io.ovf = g_st[STAGES-1].g_ov.o;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed table plus randomized streams against an arithmetic reference model
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(32)) i32 ();
    pipelined_cla_adder_if #(.WIDTH(8))  i8 ();
    pipelined_cla_adder_if #(.WIDTH(64)) i64 ();
    pipelined_cla_adder #(.WIDTH(32), .LANE_W(8))  d32 (.clk(clk), .rst(rst), .io(i32.slave));
    pipelined_cla_adder #(.WIDTH(8),  .LANE_W(8))  d8  (.clk(clk), .rst(rst), .io(i8.slave));
    pipelined_cla_adder #(.WIDTH(64), .LANE_W(16)) d64 (.clk(clk), .rst(rst), .io(i64.slave));

    typedef struct {
        logic [63:0] sum;
        logic cout;
        logic ovf;
    } res_t;
    typedef struct {
        logic [31:0] a, b;
        logic cin, sub;
        logic [31:0] s;
        logic co, ov;
    } vec_t;

    int npass = 0, ntot = 0;
    res_t q32[$], q8[$], q64[$];
    int n32 = 0, n8 = 0, n64 = 0, p8 = 0, p64 = 0, nst32 = 0;
    logic st32 = 1'b0;
    logic [34:0] h32;

    task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(string nm);
        ntot++;
        $display("FAIL %s", nm);
    endtask

    // Whole-number reference: {cout,sum} = a + b' + cin', ovf by the operand/result sign rule
    function automatic res_t model(int w, input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        res_t r;
        logic [64:0] t;
        logic [63:0] m, aa, bb;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << w) - 64'd1;
        aa = a & m;
        bb = (sub ? ~b : b) & m;
        t = {1'b0, aa} + {1'b0, bb} + 65'(sub | cin);
        r.sum = t[63:0] & m;
        r.cout = t[w];
        r.ovf = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q32.delete();
            st32 = 1'b0;
        end else begin
            if (i32.out_valid && i32.out_ready) begin
                if (q32.size() == 0) fail("d32 spurious output");
                else begin
                    e = q32.pop_front();
                    n32++;
                    chk("d32 result {cout,ovf,sum}", {i32.cout, i32.ovf, i32.sum}, {e.cout, e.ovf, e.sum[31:0]});
                end
            end
            if (i32.out_valid && !i32.out_ready) begin
                nst32++;
                chk("d32 in_ready during stall", i32.in_ready, 0);
            end
            if (st32) chk("d32 output held during stall", {i32.out_valid, i32.cout, i32.ovf, i32.sum}, h32);
            st32 = i32.out_valid && !i32.out_ready;
            h32 = {i32.out_valid, i32.cout, i32.ovf, i32.sum};
            if (i32.in_valid && i32.in_ready) q32.push_back(model(32, 64'(i32.a), 64'(i32.b), i32.cin, i32.sub));
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst) q8.delete();
        else begin
            if (i8.out_valid && i8.out_ready) begin
                if (q8.size() == 0) fail("d8 spurious output");
                else begin
                    e = q8.pop_front();
                    n8++;
                    chk("d8 result {cout,ovf,sum}", {i8.cout, i8.ovf, i8.sum}, {e.cout, e.ovf, e.sum[7:0]});
                end
            end
            if (i8.in_valid && i8.in_ready) begin
                p8++;
                q8.push_back(model(8, 64'(i8.a), 64'(i8.b), i8.cin, i8.sub));
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst) q64.delete();
        else begin
            if (i64.out_valid && i64.out_ready) begin
                if (q64.size() == 0) fail("d64 spurious output");
                else begin
                    e = q64.pop_front();
                    n64++;
                    chk("d64 result {cout,ovf,sum}", {i64.cout, i64.ovf, i64.sum}, {e.cout, e.ovf, e.sum});
                end
            end
            if (i64.in_valid && i64.in_ready) begin
                p64++;
                q64.push_back(model(64, i64.a, i64.b, i64.cin, i64.sub));
            end
        end
    end

    task automatic rnd32();
        i32.a = $urandom();
        i32.b = ($urandom_range(0, 3) == 0) ? ~i32.a : $urandom();
        i32.cin = 1'($urandom());
        i32.sub = 1'($urandom());
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && (q32.size() != 0 || q8.size() != 0 || q64.size() != 0); t++) @(posedge clk);
        #1;
    endtask

    vec_t tbl [8];
    int bad, n0, s0, sent, t, cnt, cyc;
    logic acc;

    initial begin
        tbl[0] = '{32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[4] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[5] = '{32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'd10, 32'd3, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        {i32.in_valid, i32.a, i32.b, i32.cin, i32.sub} = '0;
        {i8.in_valid, i8.a, i8.b, i8.cin, i8.sub} = '0;
        {i64.in_valid, i64.a, i64.b, i64.cin, i64.sub} = '0;
        i32.out_ready = 1'b1;
        i8.out_ready = 1'b1;
        i64.out_ready = 1'b1;
        #7;
        chk("d32 reset out_valid/in_ready", {i32.out_valid, i32.in_ready}, 2'b01);
        chk("d32 reset {sum,cout,ovf}", {i32.sum, i32.cout, i32.ovf}, 0);
        chk("d8 reset out_valid/in_ready/sum", {i8.out_valid, i8.in_ready, i8.sum}, {2'b01, 8'h00});
        chk("d64 reset out_valid/in_ready/sum", {i64.out_valid, i64.in_ready, i64.sum}, {2'b01, 64'h0});
        #15 rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: one op at a time, latency and exact result
        for (int i = 0; i < 8; i++) begin
            i32.a = tbl[i].a;
            i32.b = tbl[i].b;
            i32.cin = tbl[i].cin;
            i32.sub = tbl[i].sub;
            i32.in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("dir%0d in_ready", i), i32.in_ready, 1);
            @(posedge clk); #1;
            i32.in_valid = 1'b0;
            cyc = 1;
            while (!i32.out_valid && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("dir%0d latency", i), cyc, 4);
            chk($sformatf("dir%0d sum", i), i32.sum, tbl[i].s);
            chk($sformatf("dir%0d cout/ovf", i), {i32.cout, i32.ovf}, {tbl[i].co, tbl[i].ov});
            @(posedge clk); #1;
        end

        // Full throughput
        n0 = n32;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            rnd32();
            i32.in_valid = 1'b1;
            @(negedge clk);
            if (!i32.in_ready) bad++;
            @(posedge clk); #1;
        end
        i32.in_valid = 1'b0;
        chk("full-rate in_ready low cycles", bad, 0);
        drain();
        chk("full-rate result count", n32 - n0, 100);

        // Backpressure: out_ready low for 5 cycles mid-stream
        n0 = n32;
        s0 = nst32;
        sent = 0;
        t = 0;
        while (sent < 10 && t < 60) begin
            i32.out_ready = !(t >= 4 && t < 9);
            if (!i32.in_valid) begin
                rnd32();
                i32.in_valid = 1'b1;
            end
            @(negedge clk);
            acc = i32.in_valid && i32.in_ready;
            @(posedge clk); #1;
            t++;
            if (acc) begin
                sent++;
                i32.in_valid = 1'b0;
            end
        end
        i32.in_valid = 1'b0;
        i32.out_ready = 1'b1;
        chk("backpressure ops sent", sent, 10);
        chk("backpressure stall cycles", nst32 - s0, 5);
        drain();
        chk("backpressure result count", n32 - n0, 10);

        // Asynchronous reset with operations in flight
        for (int i = 0; i < 6; i++) begin
            rnd32();
            i32.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("pre-reset out_valid", i32.out_valid, 1);
        #2;
        rst = 1'b1;
        i32.in_valid = 1'b0;
        #1;
        chk("async reset out_valid/in_ready", {i32.out_valid, i32.in_ready}, 2'b01);
        chk("async reset {sum,cout,ovf}", {i32.sum, i32.cout, i32.ovf}, 0);
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (i32.out_valid) cnt++;
        end
        chk("post-reset stale results", cnt, 0);
        @(posedge clk); #1;

        // Degenerate single-stage and wide-lane configurations
        i8.a = 8'hFF;
        i8.b = 8'h01;
        i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        chk("d8 latency-1 out_valid", i8.out_valid, 1);
        chk("d8 carry wrap {cout,ovf,sum}", {i8.cout, i8.ovf, i8.sum}, {2'b10, 8'h00});
        i64.a = 64'hFFFF_FFFF_FFFF_FFFF;
        i64.b = 64'h0;
        i64.cin = 1'b1;
        i64.in_valid = 1'b1;
        @(posedge clk); #1;
        i64.in_valid = 1'b0;
        cyc = 1;
        while (!i64.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("d64 latency", cyc, 4);
        chk("d64 full carry {cout,ovf,sum}", {i64.cout, i64.ovf, i64.sum}, {2'b10, 64'h0});
        @(posedge clk); #1;

        // Random traffic on all three, random backpressure on the 32-bit unit
        n0 = n32;
        for (int i = 0; i < 300; i++) begin
            rnd32();
            i32.in_valid = $urandom_range(0, 3) != 0;
            i32.out_ready = $urandom_range(0, 3) != 0;
            i8.a = 8'($urandom());
            i8.b = 8'($urandom());
            i8.cin = 1'($urandom());
            i8.sub = 1'($urandom());
            i8.in_valid = $urandom_range(0, 3) != 0;
            i64.a = {$urandom(), $urandom()};
            i64.b = ($urandom_range(0, 3) == 0) ? ~i64.a : {$urandom(), $urandom()};
            i64.cin = 1'($urandom());
            i64.sub = 1'($urandom());
            i64.in_valid = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        i32.in_valid = 1'b0;
        i8.in_valid = 1'b0;
        i64.in_valid = 1'b0;
        i32.out_ready = 1'b1;
        drain();
        chk("random d32 queue drained", q32.size(), 0);
        chk("random d8 results vs accepts", n8, p8);
        chk("random d64 results vs accepts", n64, p64);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
